guess_digit_ctrl: RTL and testbench

- Game controller for the 4-digit guess-number game; sits directly upstream of the 4-digit seven-segment decoder and drives its four BCD digit inputs.
- Holds a loaded secret, lets the player build a guess with inc/next/enter button pulses, and scores the guess sequentially as A (right digit, right place) and B (right digit, wrong place).
- Shows the score for a fixed time, counts attempts, and ends the game on a win or when attempts run out.
- Digit code 4'hF means blank; the decoder blanks all codes 10-15.

---
 rtl/guess_digit_ctrl.sv | 164 ++++++++++++++++
 tb/tb_guess_digit_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_digit_ctrl.sv
// rtl/guess_digit_ctrl.sv - guess-number game controller feeding a 4-digit BCD display
// Scores one guess position per cycle in CHECK, then shows A/B or ends the game.
module guess_digit_ctrl #(
  parameter int SHOW_CYCLES = 50000000,
  parameter int MAX_TRIES   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        secret_load,
  input  logic [15:0] secret_in,
  input  logic        btn_inc,
  input  logic        btn_next,
  input  logic        btn_enter,
  output logic [3:0]  dig_0,
  output logic [3:0]  dig_1,
  output logic [3:0]  dig_2,
  output logic [3:0]  dig_3,
  output logic [1:0]  cursor,
  output logic [2:0]  a_count,
  output logic [2:0]  b_count,
  output logic        result_valid,
  output logic [3:0]  attempts,
  output logic        win,
  output logic        lose,
  output logic        secret_err,
  output logic        dup_err
);
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, SHOW, DONE} state_t;

  localparam int            SW        = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_CYCLES - 1);
  localparam logic [3:0]    LAST_TRY  = 4'(MAX_TRIES - 1);
  localparam logic [3:0]    BLANK     = 4'hF;

  state_t        state;
  logic [15:0]   secret;
  logic [15:0]   guess;
  logic [1:0]    idx;
  logic [SW-1:0] show_cnt;

  function automatic logic all_distinct(input logic [15:0] v);
    all_distinct = (v[3:0]  != v[7:4])   && (v[3:0]  != v[11:8])  && (v[3:0]  != v[15:12]) &&
                   (v[7:4]  != v[11:8])  && (v[7:4]  != v[15:12]) && (v[11:8] != v[15:12]);
  endfunction

  function automatic logic all_bcd(input logic [15:0] v);
    all_bcd = (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
  endfunction

  logic [3:0] g_digit;
  logic [3:0] cur_digit;
  logic [3:0] cur_next;
  logic       hit_a;
  logic       hit_b;
  logic       final_win;
  logic       load_ok;

  always_comb begin
    g_digit   = guess[{idx, 2'b00} +: 4];
    hit_a     = (g_digit == secret[{idx, 2'b00} +: 4]);
    hit_b     = !hit_a && ((g_digit == secret[3:0])  || (g_digit == secret[7:4]) ||
                           (g_digit == secret[11:8]) || (g_digit == secret[15:12]));
    final_win = (a_count + 3'(hit_a)) == 3'd4;
    cur_digit = guess[{cursor, 2'b00} +: 4];
    cur_next  = (cur_digit >= 4'd9) ? 4'd0 : cur_digit + 4'd1;
    load_ok   = all_bcd(secret_in) && all_distinct(secret_in);
  end

  always_comb begin
    {dig_3, dig_2, dig_1, dig_0} = {4{BLANK}};
    case (state)
      ENTRY, CHECK: {dig_3, dig_2, dig_1, dig_0} = guess;
      SHOW:         {dig_3, dig_2, dig_1, dig_0} = {1'b0, a_count, BLANK, 1'b0, b_count, BLANK};
      DONE:         {dig_3, dig_2, dig_1, dig_0} = secret;
      default:      ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      secret       <= '0;
      guess        <= '0;
      idx          <= '0;
      show_cnt     <= '0;
      cursor       <= 2'd3;
      a_count      <= '0;
      b_count      <= '0;
      attempts     <= '0;
      win          <= 1'b0;
      lose         <= 1'b0;
      result_valid <= 1'b0;
      secret_err   <= 1'b0;
      dup_err      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      secret_err   <= 1'b0;
      dup_err      <= 1'b0;
      if (secret_load && load_ok) begin
        secret   <= secret_in;
        guess    <= '0;
        cursor   <= 2'd3;
        attempts <= '0;
        a_count  <= '0;
        b_count  <= '0;
        win      <= 1'b0;
        lose     <= 1'b0;
        state    <= ENTRY;
      end else begin
        // A rejected load still masks the buttons for that cycle; timers keep running.
        secret_err <= secret_load;
        case (state)
          ENTRY: begin
            if (!secret_load) begin
              if (btn_enter) begin
                if (all_distinct(guess)) begin
                  a_count <= '0;
                  b_count <= '0;
                  idx     <= '0;
                  state   <= CHECK;
                end else begin
                  dup_err <= 1'b1;
                end
              end else if (btn_next) begin
                cursor <= cursor - 2'd1;
              end else if (btn_inc) begin
                guess[{cursor, 2'b00} +: 4] <= cur_next;
              end
            end
          end
          CHECK: begin
            a_count <= a_count + 3'(hit_a);
            b_count <= b_count + 3'(hit_b);
            idx     <= idx + 2'd1;
            if (idx == 2'd3) begin
              attempts     <= attempts + 4'd1;
              result_valid <= 1'b1;
              show_cnt     <= '0;
              if (final_win) begin
                win   <= 1'b1;
                state <= DONE;
              end else if (attempts == LAST_TRY) begin
                lose  <= 1'b1;
                state <= DONE;
              end else begin
                state <= SHOW;
              end
            end
          end
          SHOW: begin
            if (show_cnt == SHOW_LAST) begin
              cursor <= 2'd3;
              state  <= ENTRY;
            end else begin
              show_cnt <= show_cnt + SW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_guess_digit_ctrl.sv
// tb/tb_guess_digit_ctrl.sv - directed and random bench for guess_digit_ctrl
// Game-level reference model: digit arrays, loop-based A/B scoring, phase countdowns.
module tb_guess_digit_ctrl;
  localparam int SC = 5;
  localparam int MT = 2;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_SHOW = 3, M_DONE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        secret_load = 1'b0;
  logic [15:0] secret_in = '0;
  logic        btn_inc = 1'b0;
  logic        btn_next = 1'b0;
  logic        btn_enter = 1'b0;
  logic [3:0]  dig_0, dig_1, dig_2, dig_3;
  logic [1:0]  cursor;
  logic [2:0]  a_count, b_count;
  logic        result_valid;
  logic [3:0]  attempts;
  logic        win, lose, secret_err, dup_err;

  guess_digit_ctrl #(.SHOW_CYCLES(SC), .MAX_TRIES(MT)) dut (
    .clk(clk), .rst(rst), .secret_load(secret_load), .secret_in(secret_in),
    .btn_inc(btn_inc), .btn_next(btn_next), .btn_enter(btn_enter),
    .dig_0(dig_0), .dig_1(dig_1), .dig_2(dig_2), .dig_3(dig_3),
    .cursor(cursor), .a_count(a_count), .b_count(b_count),
    .result_valid(result_valid), .attempts(attempts), .win(win), .lose(lose),
    .secret_err(secret_err), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int mode, cnt, mcur, matt, ma, mb, pend_a, pend_b;
  int ms[4];
  int mg[4];
  bit mwin, mlose, e_rv, e_serr, e_derr;

  function automatic bit valid_secret(input logic [15:0] v);
    int d[4];
    for (int i = 0; i < 4; i++) d[i] = int'(v[4*i +: 4]);
    for (int i = 0; i < 4; i++) if (d[i] > 9) return 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++) if (d[i] == d[j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit guess_distinct();
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++) if (mg[i] == mg[j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] make_valid();
    int d[10];
    int j, t;
    for (int i = 0; i < 10; i++) d[i] = i;
    for (int i = 0; i < 4; i++) begin
      j = int'($urandom_range(i, 9));
      t = d[i]; d[i] = d[j]; d[j] = t;
    end
    return {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
  endfunction

  task automatic score();
    bit f;
    pend_a = 0;
    pend_b = 0;
    for (int i = 0; i < 4; i++) begin
      if (mg[i] == ms[i]) pend_a++;
      else begin
        f = 1'b0;
        for (int j = 0; j < 4; j++) if (mg[i] == ms[j]) f = 1'b1;
        if (f) pend_b++;
      end
    end
  endtask

  function automatic logic [15:0] model_disp();
    case (mode)
      M_IDLE:           return 16'hFFFF;
      M_ENTRY, M_CHECK: return {4'(mg[3]), 4'(mg[2]), 4'(mg[1]), 4'(mg[0])};
      M_SHOW:           return {4'(ma), 4'hF, 4'(mb), 4'hF};
      default:          return {4'(ms[3]), 4'(ms[2]), 4'(ms[1]), 4'(ms[0])};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".disp"}, {dig_3, dig_2, dig_1, dig_0}, model_disp());
    chk({tag, ".cursor"}, 16'(cursor), 16'(mcur));
    chk({tag, ".attempts"}, 16'(attempts), 16'(matt));
    chk({tag, ".win"}, 16'(win), 16'(mwin));
    chk({tag, ".lose"}, 16'(lose), 16'(mlose));
    chk({tag, ".result_valid"}, 16'(result_valid), 16'(e_rv));
    chk({tag, ".secret_err"}, 16'(secret_err), 16'(e_serr));
    chk({tag, ".dup_err"}, 16'(dup_err), 16'(e_derr));
    if (mode != M_CHECK) begin
      chk({tag, ".a_count"}, 16'(a_count), 16'(ma));
      chk({tag, ".b_count"}, 16'(b_count), 16'(mb));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mode = M_IDLE; mcur = 3; matt = 0; ma = 0; mb = 0; mwin = 0; mlose = 0;
    for (int i = 0; i < 4; i++) begin ms[i] = 0; mg[i] = 0; end
    e_rv = 0; e_serr = 0; e_derr = 0;
    check_all(tag);
  endtask

  task automatic do_cycle(input string tag, input logic ld, input logic [15:0] sv,
                          input logic bi, input logic bn, input logic be);
    secret_load = ld; secret_in = sv; btn_inc = bi; btn_next = bn; btn_enter = be;
    e_rv = 0; e_serr = 0; e_derr = 0;
    if (ld && valid_secret(sv)) begin
      for (int i = 0; i < 4; i++) begin ms[i] = int'(sv[4*i +: 4]); mg[i] = 0; end
      mcur = 3; matt = 0; ma = 0; mb = 0; mwin = 0; mlose = 0; mode = M_ENTRY;
    end else begin
      if (ld) e_serr = 1;
      case (mode)
        M_ENTRY: if (!ld) begin
          if (be) begin
            if (guess_distinct()) begin score(); mode = M_CHECK; cnt = 4; end
            else e_derr = 1;
          end else if (bn) mcur = (mcur + 3) % 4;
          else if (bi) mg[mcur] = (mg[mcur] + 1) % 10;
        end
        M_CHECK: begin
          cnt--;
          if (cnt == 0) begin
            ma = pend_a; mb = pend_b; matt++; e_rv = 1;
            if (ma == 4) begin mwin = 1; mode = M_DONE; end
            else if (matt == MT) begin mlose = 1; mode = M_DONE; end
            else begin mode = M_SHOW; cnt = SC; end
          end
        end
        M_SHOW: begin
          cnt--;
          if (cnt == 0) begin mode = M_ENTRY; mcur = 3; end
        end
        default: ;
      endcase
    end
    tick();
    secret_load = 1'b0; btn_inc = 1'b0; btn_next = 1'b0; btn_enter = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle("idle", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic inc_n(input int n);
    for (int i = 0; i < n; i++) do_cycle("inc", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic nxt();
    do_cycle("next", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic enter();
    do_cycle("enter", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic load(input logic [15:0] v);
    do_cycle("load", 1'b1, v, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic        ld, bi, bn, be;
    logic [15:0] sv;
    int          r;

    do_reset("reset");
    chk("reset_disp", {dig_3, dig_2, dig_1, dig_0}, 16'hFFFF);
    chk("reset_cursor", 16'(cursor), 16'd3);
    idle(2);

    load(16'h1123);
    chk("dup_secret_err", 16'(secret_err), 16'd1);
    load(16'h12A4);
    chk("bcd_secret_err", 16'(secret_err), 16'd1);
    chk("idle_blank", {dig_3, dig_2, dig_1, dig_0}, 16'hFFFF);

    load(16'h1234);
    chk("load_disp", {dig_3, dig_2, dig_1, dig_0}, 16'h0000);
    idle(4);

    // Build 4321 and score it against 1234: 0A 4B.
    inc_n(4); nxt(); inc_n(3); nxt(); inc_n(2); nxt(); inc_n(1);
    chk("guess_4321", {dig_3, dig_2, dig_1, dig_0}, 16'h4321);
    enter();
    idle(3);
    chk("rv_not_yet", 16'(result_valid), 16'd0);
    idle(1);
    chk("rv_5th", 16'(result_valid), 16'd1);
    chk("show_disp", {dig_3, dig_2, dig_1, dig_0}, 16'h0F4F);
    idle(SC - 1);
    chk("show_held", {dig_3, dig_2, dig_1, dig_0}, 16'h0F4F);
    idle(1);
    chk("guess_kept", {dig_3, dig_2, dig_1, dig_0}, 16'h4321);
    chk("attempts_1", 16'(attempts), 16'd1);

    // 4321 -> 1134 (duplicate), then 1234 wins.
    inc_n(7); nxt(); inc_n(8); nxt(); inc_n(1); nxt(); inc_n(3);
    chk("guess_1134", {dig_3, dig_2, dig_1, dig_0}, 16'h1134);
    enter();
    chk("dup_err", 16'(dup_err), 16'd1);
    nxt(); nxt(); inc_n(1);
    enter();
    idle(4);
    chk("win", 16'(win), 16'd1);
    chk("win_a", 16'(a_count), 16'd4);
    chk("win_disp", {dig_3, dig_2, dig_1, dig_0}, 16'h1234);
    inc_n(2); nxt(); enter();

    // Two misses against 9876 exhaust MAX_TRIES.
    load(16'h9876);
    nxt(); inc_n(1); nxt(); inc_n(2); nxt(); inc_n(3);
    enter(); idle(4 + SC);
    enter(); idle(4);
    chk("lose", 16'(lose), 16'd1);
    chk("lose_attempts", 16'(attempts), 16'd2);
    chk("lose_disp", {dig_3, dig_2, dig_1, dig_0}, 16'h9876);
    enter(); inc_n(1); nxt();
    load(16'h5031);
    chk("lose_cleared", 16'(lose), 16'd0);

    // Enter together with inc: only enter acts.
    do_cycle("enter_inc_dup", 1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    chk("enter_inc_noinc", {dig_3, dig_2, dig_1, dig_0}, 16'h0000);
    nxt(); inc_n(1); nxt(); inc_n(2); nxt(); inc_n(3);
    do_cycle("enter_inc_go", 1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    chk("enter_inc_guess", {dig_3, dig_2, dig_1, dig_0}, 16'h0123);
    idle(2);
    do_reset("mid_check_rst");
    chk("rst_disp", {dig_3, dig_2, dig_1, dig_0}, 16'hFFFF);

    for (int c = 0; c < 3000; c++) begin
      ld = 1'b0;
      sv = 16'h0;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        ld = 1'b1;
        sv = make_valid();
      end else if (r < 5 && (mode == M_IDLE || mode == M_ENTRY || mode == M_DONE)) begin
        ld = 1'b1;
        sv = 16'($urandom());
      end
      bi = !ld && ($urandom_range(0, 2) == 0);
      bn = !ld && ($urandom_range(0, 5) == 0);
      be = !ld && ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 599) == 0) do_reset("rand_rst");
      else do_cycle("rand", ld, sv, bi, bn, be);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
